// File: rtl/time_syn_frame_parser.sv
// Time-sync frame decoder on the MAC RX AXI-Stream: validates and classifies frames,
// presents TS / RET / STD time values with a one-cycle pulse at a fixed latency of 2.
module time_syn_frame_parser #(
    parameter logic [15:0] P_MAGIC     = 16'h5453,
    parameter int          P_FRAME_LEN = 8,
    parameter logic [7:0]  P_TYPE_TS   = 8'h01,
    parameter logic [7:0]  P_TYPE_RET  = 8'h02,
    parameter logic [7:0]  P_TYPE_STD  = 8'h03,
    parameter int          P_ERR_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_axis_tvalid,
    input  logic [63:0]        i_rx_axis_tdata,
    input  logic               i_rx_axis_tlast,
    input  logic [7:0]         i_rx_axis_tkeep,
    input  logic               i_rx_axis_tuser,
    output logic [63:0]        o_recv_time_stamp,
    output logic               o_recv_ts_valid,
    output logic [63:0]        o_recv_return_ts,
    output logic               o_recv_return_valid,
    output logic [63:0]        o_recv_std_time,
    output logic               o_recv_std_valid,
    output logic               o_frame_err,
    output logic [P_ERR_W-1:0] o_frame_err_cnt
);

    localparam logic [7:0] LAST_CNT = 8'(P_FRAME_LEN - 1);

    typedef enum logic [1:0] {S_HDR, S_BODY, S_DROP} state_t;

    function automatic logic type_known(input logic [7:0] t);
        return (t == P_TYPE_TS) || (t == P_TYPE_RET) || (t == P_TYPE_STD);
    endfunction

    function automatic logic [P_ERR_W-1:0] sat_inc(input logic [P_ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic        vld_p1;
    logic [63:0] data_p1;
    logic        last_p1;
    logic [7:0]  keep_p1;
    logic        user_p1;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  type_r, type_n;
    logic [63:0] cand, cand_n;
    logic        bad, bad_n;
    logic        resync, resync_n;
    logic        commit, err_det, bad_cur;

    // Stage 1: register every rx input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            keep_p1 <= '0;
            user_p1 <= 1'b0;
        end else begin
            vld_p1  <= i_rx_axis_tvalid;
            data_p1 <= i_rx_axis_tdata;
            last_p1 <= i_rx_axis_tlast;
            keep_p1 <= i_rx_axis_tkeep;
            user_p1 <= i_rx_axis_tuser;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_HDR;
            cnt    <= '0;
            type_r <= '0;
            cand   <= '0;
            bad    <= 1'b0;
            resync <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            type_r <= type_n;
            cand   <= cand_n;
            bad    <= bad_n;
            resync <= resync_n;
        end
    end

    // After reset the tail of an interrupted frame is dropped silently until a tlast or a good header
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        type_n   = type_r;
        cand_n   = cand;
        bad_n    = bad;
        resync_n = resync;
        commit   = 1'b0;
        err_det  = 1'b0;
        bad_cur  = bad | (keep_p1 != 8'hFF);
        if (vld_p1) begin
            case (state)
                S_HDR: begin
                    if (last_p1) begin
                        err_det  = 1'b1;
                        resync_n = 1'b0;
                    end else if (data_p1[63:48] == P_MAGIC && type_known(data_p1[47:40]) &&
                                 keep_p1 == 8'hFF) begin
                        type_n   = data_p1[47:40];
                        cnt_n    = 8'd1;
                        bad_n    = 1'b0;
                        resync_n = 1'b0;
                        state_n  = S_BODY;
                    end else begin
                        state_n = S_DROP;
                    end
                end
                S_BODY: begin
                    if (cnt == 8'd1) cand_n = data_p1;
                    bad_n = bad_cur;
                    if (last_p1) begin
                        state_n = S_HDR;
                        if (cnt == LAST_CNT && !bad_cur && !user_p1) commit  = 1'b1;
                        else                                          err_det = 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        state_n = S_DROP;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                S_DROP: begin
                    if (last_p1) begin
                        err_det  = 1'b1;
                        resync_n = 1'b0;
                        state_n  = S_HDR;
                    end
                end
                default: state_n = S_HDR;
            endcase
        end
    end

    // Stage 2: commit to the typed output register, pulse outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_recv_time_stamp   <= '0;
            o_recv_ts_valid     <= 1'b0;
            o_recv_return_ts    <= '0;
            o_recv_return_valid <= 1'b0;
            o_recv_std_time     <= '0;
            o_recv_std_valid    <= 1'b0;
            o_frame_err         <= 1'b0;
            o_frame_err_cnt     <= '0;
        end else begin
            o_recv_ts_valid     <= commit && (type_r == P_TYPE_TS);
            o_recv_return_valid <= commit && (type_r == P_TYPE_RET);
            o_recv_std_valid    <= commit && (type_r == P_TYPE_STD);
            o_frame_err         <= err_det && !resync;
            if (commit && type_r == P_TYPE_TS)  o_recv_time_stamp <= cand;
            if (commit && type_r == P_TYPE_RET) o_recv_return_ts  <= cand;
            if (commit && type_r == P_TYPE_STD) o_recv_std_time   <= cand;
            if (err_det && !resync) o_frame_err_cnt <= sat_inc(o_frame_err_cnt);
        end
    end

endmodule

// File: tb/tb_time_syn_frame_parser.sv
// Scoreboard bench for time_syn_frame_parser: stimulus pushes expected pulses, a monitor pops and compares.
module tb_time_syn_frame_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;

    logic [63:0] ts, ret, stdt;
    logic        ts_v, ret_v, std_v, err;
    logic [15:0] err_cnt;

    logic [63:0] ts2, ret2, stdt2;
    logic        ts_v2, ret_v2, std_v2, err2;
    logic [3:0]  err_cnt2;

    always #5 clk = ~clk;

    time_syn_frame_parser dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
        .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser),
        .o_recv_time_stamp(ts), .o_recv_ts_valid(ts_v),
        .o_recv_return_ts(ret), .o_recv_return_valid(ret_v),
        .o_recv_std_time(stdt), .o_recv_std_valid(std_v),
        .o_frame_err(err), .o_frame_err_cnt(err_cnt)
    );

    time_syn_frame_parser #(.P_ERR_W(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
        .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser),
        .o_recv_time_stamp(ts2), .o_recv_ts_valid(ts_v2),
        .o_recv_return_ts(ret2), .o_recv_return_valid(ret_v2),
        .o_recv_std_time(stdt2), .o_recv_std_valid(std_v2),
        .o_frame_err(err2), .o_frame_err_cnt(err_cnt2)
    );

    typedef struct {
        int          kind;   // 0 TS, 1 RET, 2 STD, 3 ERR
        logic [63:0] val;
        int          cyc;
        logic [15:0] cnt;
    } ev_t;

    ev_t         exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    int          err2_pulses = 0;
    logic [15:0] exp_cnt = '0;
    logic [63:0] m_ts = '0, m_ret = '0, m_std = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (err2) err2_pulses <= err2_pulses + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic fail(input string name, input int act, input int expv);
        checks++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Monitor: one pulse per frame, compared against the head of the queue
    always @(negedge clk) begin
        int  npulse;
        int  akind;
        ev_t e;
        if (rst_n) begin
            npulse = int'(ts_v) + int'(ret_v) + int'(std_v) + int'(err);
            akind  = ts_v ? 0 : ret_v ? 1 : std_v ? 2 : 3;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                fail("missing_pulse", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (npulse > 1) begin
                fail("multi_pulse", npulse, 1);
            end else if (npulse == 1) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_pulse_kind", akind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    check("pulse_kind", 64'(akind), 64'(e.kind));
                    if (e.kind == 0) m_ts  = e.val;
                    if (e.kind == 1) m_ret = e.val;
                    if (e.kind == 2) m_std = e.val;
                    check("time_stamp", ts, m_ts);
                    check("return_ts", ret, m_ret);
                    check("std_time", stdt, m_std);
                    check("err_cnt", 64'(err_cnt), 64'(e.cnt));
                end
            end
        end
    end

    task automatic beat(input logic [63:0] d, input logic last, input logic [7:0] keep, input logic user);
        @(posedge clk); #1;
        tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep; tuser = user;
    endtask

    // Idle cycles carry junk with tvalid low, which must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tvalid = 1'b0; tdata = 64'h5453_0100_0000_0000; tlast = 1'b1; tkeep = 8'h00; tuser = 1'b1;
        end
    endtask

    task automatic push(input int kind, input logic [63:0] val);
        ev_t e;
        if (kind == 3 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.kind = kind; e.val = val; e.cyc = cyc + 2; e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [15:0] magic, input logic [7:0] typ, input logic [63:0] t,
                              input int n, input logic user, input int badk, input bit gaps);
        logic [63:0] d;
        bit          good;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) idle($urandom_range(0, 2));
            d = (i == 0) ? {magic, typ, 40'h0} : (i == 1) ? t : 64'hA5A5_A5A5_0000_0000 + 64'(i);
            beat(d, i == n - 1, (i == badk) ? 8'h0F : 8'hFF, (i == n - 1) ? user : 1'b0);
        end
        good = (magic == 16'h5453) && (typ >= 8'h01 && typ <= 8'h03) && (n == 8) &&
               !user && !(badk >= 0 && badk < n);
        push(good ? int'(typ) - 1 : 3, t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ts"}, ts, 64'h0);
        check({tag, "_ret"}, ret, 64'h0);
        check({tag, "_std"}, stdt, 64'h0);
        check({tag, "_pulses"}, {60'h0, ts_v, ret_v, std_v, err}, 64'h0);
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
        check({tag, "_err_cnt4"}, 64'(err_cnt2), 64'h0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tkeep = '0; tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Good TS frame
        send_frame(16'h5453, 8'h01, 64'h1234, 8, 1'b0, -1, 1'b0);
        idle(2);

        // Back-to-back RET then STD with gaps inside frames
        send_frame(16'h5453, 8'h02, 64'hA, 8, 1'b0, -1, 1'b1);
        send_frame(16'h5453, 8'h03, 64'hB, 8, 1'b0, -1, 1'b1);
        idle(4);
        check("b2b_err_cnt", 64'(err_cnt), 64'h0);

        // Five bad frames, back to back
        send_frame(16'h0000, 8'h01, 64'h111, 8, 1'b0, -1, 1'b0);
        send_frame(16'h5453, 8'h07, 64'h222, 8, 1'b0, -1, 1'b0);
        send_frame(16'h5453, 8'h01, 64'h333, 7, 1'b0, -1, 1'b0);
        send_frame(16'h5453, 8'h02, 64'h444, 9, 1'b0, -1, 1'b0);
        send_frame(16'h5453, 8'h03, 64'h555, 8, 1'b1, -1, 1'b0);
        idle(4);
        check("bad5_err_cnt", 64'(err_cnt), 64'd5);
        check("bad5_ts_held", ts, 64'h1234);
        check("bad5_ret_held", ret, 64'hA);
        check("bad5_std_held", stdt, 64'hB);

        // Single-beat frame: tlast on the header beat
        send_frame(16'h5453, 8'h01, 64'h666, 1, 1'b0, -1, 1'b0);
        idle(2);

        // tkeep hole on beat 4 of an STD frame, then a good STD frame
        send_frame(16'h5453, 8'h03, 64'hC, 8, 1'b0, 4, 1'b0);
        send_frame(16'h5453, 8'h03, 64'hD, 8, 1'b0, -1, 1'b0);
        idle(4);
        check("keep_err_cnt", 64'(err_cnt), 64'd7);

        // Reset at beat 3 of a TS frame, then tail beats, then a good TS
        beat(64'h5453_0100_0000_0000, 1'b0, 8'hFF, 1'b0);
        beat(64'h77, 1'b0, 8'hFF, 1'b0);
        beat(64'hA5A5_A5A5_0000_0002, 1'b0, 8'hFF, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; tvalid = 1'b1; tdata = 64'hA5A5_A5A5_0000_0003; tlast = 1'b0; tkeep = 8'hFF; tuser = 1'b0;
        exp_q.delete(); exp_cnt = '0; m_ts = '0; m_ret = '0; m_std = '0;
        @(posedge clk); #1;
        check_zero("midrst");
        rst_n = 1'b1;
        for (int i = 4; i < 8; i++) beat(64'hA5A5_A5A5_0000_0000 + 64'(i), i == 7, 8'hFF, 1'b0);
        idle(4);
        check_zero("tail");
        send_frame(16'h5453, 8'h01, 64'h55, 8, 1'b0, -1, 1'b0);
        idle(4);
        check("post_rst_ts", ts, 64'h55);

        // Saturation on the 4-bit counter build
        base = err2_pulses;
        for (int i = 0; i < 17; i++) send_frame(16'h0000, 8'h01, 64'(i), 8, 1'b0, -1, 1'b0);
        idle(4);
        check("sat_err_cnt4", 64'(err_cnt2), 64'hF);
        check("sat_pulses4", 64'(err2_pulses - base), 64'd17);
        check("sat_err_cnt16", 64'(err_cnt), 64'd17);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) fail("drain_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
